// File: rtl/zero_reg_file.sv
// General-purpose register file: byte-strobed write port, two combinational read ports,
// pending-write scoreboard, optional hardwired-zero register 0. Define ZERO_REG_FILE_BYPASS_EN for write-to-read bypass.
module zero_reg_file #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             issue,
  input  logic [AW-1:0]    issue_addr,
  output logic             busy_a,
  output logic             busy_b
);

  localparam int unsigned NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             wr_en;
  logic             iss_en;

  // Address maps to real, writable storage (in range and not the hardwired zero register)
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  function automatic logic [WIDTH-1:0] byte_merge(input logic [WIDTH-1:0] old_v,
                                                  input logic [WIDTH-1:0] new_v,
                                                  input logic [NB-1:0]    strb);
    logic [WIDTH-1:0] m;
    m = old_v;
    for (int b = 0; b < int'(NB); b++) begin
      if (strb[b]) m[8*b +: 8] = new_v[8*b +: 8];
    end
    return m;
  endfunction

  assign wr_en  = we && addr_ok(waddr);
  assign iss_en = issue && addr_ok(issue_addr);

  // Scoreboard update: write clears, issue sets afterwards so it wins on the same address
  always_comb begin
    busy_nxt = busy;
    if (wr_en)  busy_nxt[waddr]      = 1'b0;
    if (iss_en) busy_nxt[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      busy <= '0;
    end else if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_en) mem[waddr] <= byte_merge(mem[waddr], wdata, wstrb);
      busy <= busy_nxt;
    end
  end

  // Read ports: unreadable addresses (out of range or zero register) return zero
  always_comb begin
    rdata_a = '0;
    busy_a  = 1'b0;
    if (addr_ok(raddr_a)) begin
      rdata_a = mem[raddr_a];
      busy_a  = busy[raddr_a];
`ifdef ZERO_REG_FILE_BYPASS_EN
      if (wr_en && (raddr_a == waddr)) begin
        rdata_a = byte_merge(mem[raddr_a], wdata, wstrb);
        if (!(iss_en && (issue_addr == raddr_a))) busy_a = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    rdata_b = '0;
    busy_b  = 1'b0;
    if (addr_ok(raddr_b)) begin
      rdata_b = mem[raddr_b];
      busy_b  = busy[raddr_b];
`ifdef ZERO_REG_FILE_BYPASS_EN
      if (wr_en && (raddr_b == waddr)) begin
        rdata_b = byte_merge(mem[raddr_b], wdata, wstrb);
        if (!(iss_en && (issue_addr == raddr_b))) busy_b = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_zero_reg_file.sv
// Directed bench for zero_reg_file: default config, ZERO_REG=0 and DEPTH=20 instances on shared stimulus.
module tb_zero_reg_file;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr, we, issue;
  logic [AW-1:0] waddr, raddr_a, raddr_b, issue_addr;
  logic [W-1:0]  wdata;
  logic [3:0]    wstrb;

  logic [W-1:0] rd_a, rd_b, z0_rd_a, z0_rd_b, d20_rd_a, d20_rd_b;
  logic         bs_a, bs_b, z0_bs_a, z0_bs_b, d20_bs_a, d20_bs_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  zero_reg_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr_a(raddr_a), .rdata_a(rd_a), .raddr_b(raddr_b), .rdata_b(rd_b),
    .issue(issue), .issue_addr(issue_addr), .busy_a(bs_a), .busy_b(bs_b));

  zero_reg_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b0)) dut_z0 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr_a(raddr_a), .rdata_a(z0_rd_a), .raddr_b(raddr_b), .rdata_b(z0_rd_b),
    .issue(issue), .issue_addr(issue_addr), .busy_a(z0_bs_a), .busy_b(z0_bs_b));

  zero_reg_file #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1'b1)) dut_d20 (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr_a(raddr_a), .rdata_a(d20_rd_a), .raddr_b(raddr_b), .rdata_b(d20_rd_b),
    .issue(issue), .issue_addr(issue_addr), .busy_a(d20_bs_a), .busy_b(d20_bs_b));

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [3:0]    wstrb;
    logic          issue;
    logic [AW-1:0] issue_addr;
    logic          clr;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [W-1:0]  ea;
    logic [W-1:0]  eb;
    logic          eba;
    logic          ebb;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; issue = 1'b0; clr = 1'b0; wstrb = '0; wdata = '0;
    waddr = '0; issue_addr = '0;
  endtask

  task automatic drive(input vec_t v);
    we = v.we; waddr = v.waddr; wdata = v.wdata; wstrb = v.wstrb;
    issue = v.issue; issue_addr = v.issue_addr; clr = v.clr;
    raddr_a = v.ra; raddr_b = v.rb;
  endtask

  initial begin
    //          we    wa     wdata          strb  iss   ia     clr   ra     rb     ea             eb             eba   ebb
    vecs[0]  = '{1'b1, 5'd3,  32'h11223344, 4'hF, 1'b0, 5'd0,  1'b0, 5'd3,  5'd0,  32'h11223344, 32'h0,         1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd3,  32'hAABBCCDD, 4'h5, 1'b0, 5'd0,  1'b0, 5'd3,  5'd0,  32'h11BB33DD, 32'h0,         1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'd3,  32'hFFFFFFFF, 4'h0, 1'b0, 5'd0,  1'b0, 5'd3,  5'd0,  32'h11BB33DD, 32'h0,         1'b0, 1'b0};
    vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF, 1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,         32'h0,         1'b0, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd7,  1'b0, 5'd3,  5'd7,  32'h11BB33DD, 32'h0,         1'b0, 1'b1};
    vecs[5]  = '{1'b1, 5'd7,  32'hCAFEF00D, 4'hF, 1'b0, 5'd0,  1'b0, 5'd3,  5'd7,  32'h11BB33DD, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 5'd7,  32'h12345678, 4'hF, 1'b1, 5'd7,  1'b0, 5'd3,  5'd7,  32'h11BB33DD, 32'h12345678, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 5'd7,  32'h0,        4'h0, 1'b0, 5'd0,  1'b0, 5'd3,  5'd7,  32'h11BB33DD, 32'h12345678, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'd11, 32'h00000055, 4'h1, 1'b1, 5'd10, 1'b0, 5'd10, 5'd11, 32'h0,         32'h00000055, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd11, 1'b0, 5'd11, 5'd11, 32'h00000055, 32'h00000055, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 5'd4,  32'hFFFFFFFF, 4'hF, 1'b1, 5'd4,  1'b1, 5'd4,  5'd10, 32'h0,         32'h0,         1'b0, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  1'b0, 5'd11, 5'd3,  32'h0,         32'h0,         1'b0, 1'b0};

    rst = 1'b1;
    idle();
    raddr_a = '0; raddr_b = '0;

    // Reset state across every address
    for (int i = 0; i < 32; i++) begin
      raddr_a = AW'(i); raddr_b = AW'(31 - i);
      #1;
      check($sformatf("reset rdata_a[%0d]", i), rd_a, 32'h0);
      check($sformatf("reset rdata_b[%0d]", 31 - i), rd_b, 32'h0);
      check($sformatf("reset busy[%0d]", i), {30'h0, bs_a, bs_b}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d rdata_a", i), rd_a, vecs[i].ea);
      check($sformatf("v%0d rdata_b", i), rd_b, vecs[i].eb);
      check($sformatf("v%0d busy_a", i), 32'(bs_a), 32'(vecs[i].eba));
      check($sformatf("v%0d busy_b", i), 32'(bs_b), 32'(vecs[i].ebb));
    end

    // Same-cycle read of a location being written
    @(negedge clk);
    idle();
    we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5; wstrb = 4'hF; raddr_a = 5'd9; raddr_b = 5'd0;
    @(posedge clk);
    #1;
    check("bypass setup", rd_a, 32'hA5A5A5A5);
    @(negedge clk);
    wdata = 32'h12345678;
    #1;
`ifdef ZERO_REG_FILE_BYPASS_EN
    check("bypass same cycle", rd_a, 32'h12345678);
`else
    check("bypass same cycle", rd_a, 32'hA5A5A5A5);
`endif
    check("bypass busy_a", 32'(bs_a), 32'h0);
    @(posedge clk);
    #1;
    check("bypass next cycle", rd_a, 32'h12345678);

    // Asynchronous reset in the middle of a cycle
    @(negedge clk);
    idle();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; wstrb = 4'hF; raddr_a = 5'd5; raddr_b = 5'd9;
    @(posedge clk);
    #1;
    check("pre-rst reg5", rd_a, 32'hDEADBEEF);
    idle();
    #1;
    rst = 1'b1;
    #1;
    check("async rst rdata_a", rd_a, 32'h0);
    check("async rst rdata_b", rd_b, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    we = 1'b1; waddr = 5'd5; wdata = 32'h00000001; wstrb = 4'hF; issue = 1'b1; issue_addr = 5'd9;
    @(posedge clk);
    #1;
    check("post-rst write", rd_a, 32'h00000001);
    check("post-rst issue", 32'(bs_b), 32'h1);

    // Register 0: hardwired versus ordinary storage
    @(negedge clk);
    idle();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wstrb = 4'hF; issue = 1'b1; issue_addr = 5'd0;
    raddr_a = 5'd0; raddr_b = 5'd0;
    @(posedge clk);
    #1;
    check("zreg rdata_a", rd_a, 32'h0);
    check("zreg busy_a", 32'(bs_a), 32'h0);
    check("z0 rdata_a", z0_rd_a, 32'hFFFFFFFF);
    check("z0 busy_a", 32'(z0_bs_a), 32'h1);

    // Out-of-range addresses with DEPTH=20
    @(negedge clk);
    idle();
    we = 1'b1; waddr = 5'd25; wdata = 32'hFFFFFFFF; wstrb = 4'hF; issue = 1'b1; issue_addr = 5'd25;
    raddr_a = 5'd25; raddr_b = 5'd19;
    @(posedge clk);
    #1;
    check("d20 oor rdata", d20_rd_a, 32'h0);
    check("d20 oor busy", 32'(d20_bs_a), 32'h0);
    check("d32 reg25 write", rd_a, 32'hFFFFFFFF);
    @(negedge clk);
    idle();
    we = 1'b1; waddr = 5'd19; wdata = 32'h0BADF00D; wstrb = 4'hF;
    @(posedge clk);
    #1;
    check("d20 reg19 write", d20_rd_b, 32'h0BADF00D);
    check("d20 reg25 still 0", d20_rd_a, 32'h0);

    @(negedge clk);
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/zero_reg_file.md
# zero_reg_file

Parametrised multi-register storage block with register 0 hardwired to zero, replacing the single-bit enabled register used in the datapath. It provides one byte-strobed write port, two asynchronous read ports, and a pending-write scoreboard. The processor core uses it as its general-purpose register file; issue logic uses the scoreboard to stall on read-after-write hazards.

## Interface
Parameters:
- WIDTH, 32, register width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; 2..256.
- AW, $clog2(DEPTH), address width.
- ZERO_REG, 1, if 1, register 0 reads zero, ignores writes and is never busy; if 0, register 0 is ordinary storage.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear of all registers and busy bits.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- wstrb  in  WIDTH/8  byte write strobes; bit i covers wdata[8i+7:8i].
- raddr_a  in  AW  read address, port A.
- rdata_a  out  WIDTH  read data, port A.
- raddr_b  in  AW  read address, port B.
- rdata_b  out  WIDTH  read data, port B.
- issue  in  1  marks issue_addr as pending write.
- issue_addr  in  AW  destination being issued.
- busy_a  out  1  raddr_a has a pending write.
- busy_b  out  1  raddr_b has a pending write.

## Operation
- Storage: DEPTH x WIDTH flops plus a DEPTH-bit busy vector.
- Write: on a clk edge with we=1, each byte of reg[waddr] whose wstrb bit is 1 takes wdata; other bytes hold. we=1 with wstrb=0 changes no data.
- Write also clears busy[waddr], regardless of wstrb.
- Issue: on a clk edge with issue=1, busy[issue_addr] is set.
- Issue and write on the same edge:
  - Same address: the busy bit ends at 1 (issue wins) and the data write still occurs.
  - Different addresses: both actions take effect.
- Zero register (ZERO_REG=1): writes to address 0 are ignored, issue to address 0 is ignored, reads of address 0 return 0, and busy for address 0 is 0.
- Out-of-range addresses (>= DEPTH): writes and issues are ignored, reads return 0, and busy is 0.
- Read ports: combinational from the current state and addresses. A and B are fully independent and may use the same address.
- clr: on a clk edge, all registers go to 0 and all busy bits go to 0. clr overrides we and issue in the same cycle.
- Precedence: rst > clr > issue/write.

## Timing
- Reset: while rst=1, all registers are 0 and all busy bits are 0. Therefore rdata_a=0, rdata_b=0, busy_a=0, busy_b=0.
- rst asserted mid-operation: state is cleared immediately, not waiting for clk. The first edge after deassertion behaves normally.
- Write latency: 1 cycle. Data is visible on the read ports after the edge that captures it.
- Issue latency: busy is visible after the capturing edge.
- Read latency: 0 cycles (combinational).
- Read of a location being written in the same cycle: see Configuration.

## Configuration
- Macro: ZERO_REG_FILE_BYPASS_EN.
- Defined:
  - If we=1 and raddr_x==waddr (a valid, writable address), rdata_x returns the byte-merge of wdata (strobed bytes) and the stored value (unstrobed bytes) in the same cycle.
  - busy_x is forced to 0 in that cycle, unless issue targets the same address in that cycle.
- Not defined:
  - Reads always return the stored value, so same-cycle reads see old data.
  - busy_x reflects only the registered busy vector.

## Test plan
- Reset then read: rst=1 while all addresses are read -> rdata=0 and busy=0. Write 0xDEADBEEF to reg 5, then assert rst asynchronously mid-cycle -> rdata_a for reg 5 reads 0 immediately.
- Byte strobes: write 0x11223344 to reg 3 with wstrb=4'hF, then write 0xAABBCCDD with wstrb=4'b0101 -> reg 3 reads 0x11BB33DD.
- Zero register: write 0xFFFFFFFF to reg 0 and issue reg 0 -> rdata_a for reg 0 is 0 and busy_a is 0. With ZERO_REG=0, the same stimulus reads 0xFFFFFFFF.
- Scoreboard: issue reg 7 -> busy_b=1 on the next cycle. Write reg 7 -> busy_b=0 after that edge. Issue and write reg 7 on the same edge -> busy_b stays 1 and data is updated.
- Bypass: write 0x12345678 to reg 9 while raddr_a=9 in the same cycle.
  - With ZERO_REG_FILE_BYPASS_EN: rdata_a=0x12345678 and busy_a=0 that cycle.
  - Without: old value that cycle, new value the next cycle.
- clr and range: with DEPTH=20, write reg 25 -> ignored and reads 0. Assert clr together with we to reg 4 -> reg 4=0 and all busy bits are 0.
